// File: rtl/bcd_seq_ctrl.sv
// Digit-serial BCD add/subtract sequencer: one decimal digit per clock, LSD first,
// with a ten's-complement fix pass when a subtraction goes negative.
module bcd_seq_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, COMP, DONE} state_t;

    state_t           state, state_n;
    logic [W-1:0]     a_q, b_q, a_n, b_n, result_n;
    logic             op_q, op_n, carry, carry_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             cout_n, neg_n, err_n;

    logic [3:0]       a_dig, b_dig, r_dig, cell_x, cell_y, sum_dig;
    logic [4:0]       cell_t;
    logic             cell_c, bad_digit;

    always_comb begin
        a_dig     = 4'd0;
        b_dig     = 4'd0;
        r_dig     = 4'd0;
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                a_dig = a_q[4*d +: 4];
                b_dig = b_q[4*d +: 4];
                r_dig = result[4*d +: 4];
            end
            if (a_q[4*d +: 4] > 4'd9 || b_q[4*d +: 4] > 4'd9)
                bad_digit = 1'b1;
        end

        // The single-digit adder cell is shared by the CALC and COMP passes.
        cell_x  = (state == COMP) ? 4'd9 - r_dig : a_dig;
        cell_y  = (state == COMP) ? 4'd0 : (op_q ? 4'd9 - b_dig : b_dig);
        cell_t  = {1'b0, cell_x} + {1'b0, cell_y} + {4'd0, carry};
        cell_c  = cell_t > 5'd9;
        sum_dig = cell_c ? 4'(cell_t - 5'd10) : cell_t[3:0];
    end

    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        op_n     = op_q;
        idx_n    = idx;
        carry_n  = carry;
        result_n = result;
        cout_n   = cout;
        neg_n    = neg;
        err_n    = err;

        unique case (state)
            IDLE: begin
                if (start) begin
                    a_n     = a_bcd;
                    b_n     = b_bcd;
                    op_n    = op;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                cout_n = 1'b0;
                neg_n  = 1'b0;
                if (bad_digit) begin
                    err_n    = 1'b1;
                    result_n = '0;
                    state_n  = DONE;
                end else begin
                    err_n   = 1'b0;
                    idx_n   = '0;
                    carry_n = op_q;
                    state_n = CALC;
                end
            end
            CALC, COMP: begin
                for (int d = 0; d < DIGITS; d++)
                    if (idx == IDX_W'(d))
                        result_n[4*d +: 4] = sum_dig;
                carry_n = cell_c;
                idx_n   = idx + 1'b1;
                if (idx == LAST) begin
                    state_n = DONE;
                    // A subtract with no final carry borrowed: complement the magnitude.
                    if (state == CALC && !op_q) begin
                        cout_n = cell_c;
                    end else if (state == CALC && !cell_c) begin
                        neg_n   = 1'b1;
                        idx_n   = '0;
                        carry_n = 1'b1;
                        state_n = COMP;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            a_q    <= a_n;
            b_q    <= b_n;
            op_q   <= op_n;
            idx    <= idx_n;
            carry  <= carry_n;
            result <= result_n;
            cout   <= cout_n;
            neg    <= neg_n;
            err    <= err_n;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Self-checking bench for bcd_seq_ctrl: directed vector table, reset abort and
// randomized operations against an integer-arithmetic reference model.
module tb_bcd_seq_ctrl;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         CLOCK_50 = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a_bcd, b_bcd, result;
    logic         busy, done, cout, neg, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         n;
        logic         e;
        logic         hold;
    } vec_t;

    vec_t vecs[12];

    bcd_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .start(start),
        .op(op),
        .a_bcd(a_bcd),
        .b_bcd(b_bcd),
        .busy(busy),
        .done(done),
        .result(result),
        .cout(cout),
        .neg(neg),
        .err(err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Decimal reference: operands as integers, result folded back into BCD digits.
    function automatic void ref_model(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                      output logic [W-1:0] r, output logic c, output logic n, output logic e);
        int ai, bi, v, lim;
        ai = 0; bi = 0; lim = 1; e = 1'b0; c = 1'b0; n = 1'b0; r = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (a_v[4*d +: 4] > 9 || b_v[4*d +: 4] > 9) e = 1'b1;
            ai  = ai * 10 + int'(a_v[4*d +: 4]);
            bi  = bi * 10 + int'(b_v[4*d +: 4]);
            lim = lim * 10;
        end
        if (e) return;
        if (!op_v) begin
            v = ai + bi;
            c = (v >= lim);
            v = v % lim;
        end else begin
            n = (ai < bi);
            v = n ? bi - ai : ai - bi;
        end
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

    task automatic applyStimulus(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                 input logic [W-1:0] exp_r, input logic exp_c, input logic exp_n,
                                 input logic exp_e, input logic hold_start);
        int lat, seen;
        lat  = exp_e ? 1 : (exp_n ? 2*DIGITS + 1 : DIGITS + 1);
        seen = -1;
        @(negedge CLOCK_50);
        start = 1'b1; op = op_v; a_bcd = a_v; b_bcd = b_v;
        @(negedge CLOCK_50);
        checkOutput("busy_after_accept", busy, 1);
        checkOutput("done_early", done, 0);
        if (!hold_start) start = 1'b0;
        op    = ~op_v;
        a_bcd = W'($urandom);
        b_bcd = W'($urandom);
        for (int k = 1; k <= 4*DIGITS + 8; k++) begin
            @(negedge CLOCK_50);
            if (done) begin
                seen = k;
                break;
            end
        end
        checkOutput("latency", seen, lat);
        if (seen > 0) begin
            checkOutput("result", result, exp_r);
            checkOutput("cout", cout, exp_c);
            checkOutput("neg", neg, exp_n);
            checkOutput("err", err, exp_e);
            checkOutput("busy_in_done", busy, 1);
        end
        @(negedge CLOCK_50);
        start = 1'b0;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("busy_drop", busy, 0);
        checkOutput("result_held", result, exp_r);
        @(negedge CLOCK_50);
        checkOutput("start_not_queued", busy, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic         rop, ec, en, ee, saw_done;

        vecs[0]  = '{1'b0, 8'h45, 8'h37, 8'h82, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'h99, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h99, 8'h99, 8'h98, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h52, 8'h17, 8'h35, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h40, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h17, 8'h52, 8'h35, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h00, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h1A, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h05, 8'h3F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h50, 8'h50, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h30, 8'h12, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; op = 1'b0; a_bcd = '0; b_bcd = '0;
        repeat (2) @(negedge CLOCK_50);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_flags", {cout, neg, err}, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
                          vecs[i].c, vecs[i].n, vecs[i].e, vecs[i].hold);

        // Reset asserted mid-calculation must abort without a done pulse.
        @(negedge CLOCK_50);
        start = 1'b1; op = 1'b0; a_bcd = 8'h45; b_bcd = 8'h37;
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_flags", {cout, neg, err}, 0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge CLOCK_50);
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", saw_done, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom);
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[3:0] = 4'($urandom_range(10, 15));
            ref_model(rop, ra, rb, er, ec, en, ee);
            applyStimulus(rop, ra, rb, er, ec, en, ee, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
